// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes 'l'/'L' + MMSS + CR frames from the UART byte
// stream into a validated BCD load for the time counter or alarm register.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 12000000,
  parameter logic [7:0]  CR_CODE     = 8'h0d
) (
  input  logic        clk12m,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic [15:0] ld_digits,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic        cmd_err,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, D0, D1, D2, D3, WCR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          type_q, type_d;      // 1 = alarm, 0 = time
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ld_digits_q, ld_digits_d;
  logic          ld_time_q, ld_time_d;
  logic          ld_alarm_q, ld_alarm_d;
  logic          cmd_err_q, cmd_err_d;
  logic          busy_q, busy_d;

  logic is_cmd, digit_ok, cr_ok, timeout_hit;

  // Classify the incoming byte against what the current state expects
  always_comb begin
    is_cmd   = (rx_data == 8'h6c) || (rx_data == 8'h4c);
    digit_ok = 1'b0;
    case (state_q)
      D0, D2:  digit_ok = (rx_data >= 8'h30) && (rx_data <= 8'h35);
      D1, D3:  digit_ok = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      default: digit_ok = 1'b0;
    endcase
    cr_ok       = (state_q == WCR) && (rx_data == CR_CODE);
    timeout_hit = (state_q != IDLE) && !rx_data_rdy && (cnt_q == TMO_LAST);
  end

  // State register
  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: command byte always (re)starts; any unexpected byte aborts
  always_comb begin
    state_d = state_q;
    if (rx_data_rdy) begin
      if (is_cmd) begin
        state_d = D0;
      end else if (state_q != IDLE) begin
        if (digit_ok) begin
          case (state_q)
            D0:      state_d = D1;
            D1:      state_d = D2;
            D2:      state_d = D3;
            D3:      state_d = WCR;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // Datapath/outputs: shadow capture, timeout count, load and error pulses
  always_comb begin
    shadow_d    = shadow_q;
    type_d      = type_q;
    ld_digits_d = ld_digits_q;
    ld_time_d   = 1'b0;
    ld_alarm_d  = 1'b0;
    cmd_err_d   = 1'b0;
    busy_d      = (state_d != IDLE);
    cnt_d       = (rx_data_rdy || state_d == IDLE) ? '0 : cnt_q + 1'b1;
    if (rx_data_rdy) begin
      if (is_cmd) begin
        type_d = (rx_data == 8'h4c);
      end else if (digit_ok) begin
        // low nibble of an ASCII digit equals rx_data - 8'h30
        case (state_q)
          D0:      shadow_d[15:12] = rx_data[3:0];
          D1:      shadow_d[11:8]  = rx_data[3:0];
          D2:      shadow_d[7:4]   = rx_data[3:0];
          D3:      shadow_d[3:0]   = rx_data[3:0];
          default: shadow_d        = shadow_q;
        endcase
      end else if (cr_ok) begin
        ld_digits_d = shadow_q;
        ld_time_d   = !type_q;
        ld_alarm_d  = type_q;
      end else if (state_q != IDLE) begin
        cmd_err_d = 1'b1;
      end
    end else if (timeout_hit) begin
      cmd_err_d = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      type_q      <= 1'b0;
      cnt_q       <= '0;
      ld_digits_q <= '0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      type_q      <= type_d;
      cnt_q       <= cnt_d;
      ld_digits_q <= ld_digits_d;
      ld_time_q   <= ld_time_d;
      ld_alarm_q  <= ld_alarm_d;
      cmd_err_q   <= cmd_err_d;
      busy_q      <= busy_d;
    end
  end

  assign ld_digits = ld_digits_q;
  assign ld_time   = ld_time_q;
  assign ld_alarm  = ld_alarm_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = busy_q;

endmodule
